// File: rtl/lsu.sv
`timescale 1ns/1ps
// Load/store unit: turns one core request into one or two data-memory beats and a single response.
// Optional macro LSU_MISALIGN_SPLIT_EN: split word-crossing accesses into two beats instead of trapping.
module lsu #(
    parameter int unsigned XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [2:0]        i_req_funct3,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_rsp_valid,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_trap,
    output logic [XLEN-1:0]   o_dmem_addr,
    output logic              o_dmem_ren,
    output logic              o_dmem_wen,
    output logic [XLEN-1:0]   o_dmem_wdata,
    output logic [XLEN/8-1:0] o_dmem_mask,
    input  logic              i_dmem_ready,
    input  logic              i_dmem_valid,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    output logic              o_busy
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned MW = 2 * NB;
    localparam int unsigned DW = 2 * XLEN;

    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_WAIT0, S_BEAT1, S_WAIT1, S_RESP} state_e;
    state_e state_q, state_d;

    logic            rq_wen_q, rq_wen_d;
    logic [2:0]      rq_f3_q, rq_f3_d;
    logic [XLEN-1:0] rq_addr_q, rq_addr_d;
    logic [XLEN-1:0] rq_wdata_q, rq_wdata_d;
    logic [DW-1:0]   buf_q, buf_d;

    logic            req_ready_q, req_ready_d;
    logic            busy_q, busy_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_trap_q, rsp_trap_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic            dmem_ren_q, dmem_ren_d;
    logic            dmem_wen_q, dmem_wen_d;
    logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [NB-1:0]   dmem_mask_q, dmem_mask_d;

    logic            accept;
    logic [1:0]      lg;
    logic [OW-1:0]   off;
    logic            legal;
    logic            trap;
    logic            split;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic            cross;
`else
    logic            misal;
`endif

    // Request capture, size decode and load-data buffering
    always_comb begin
        accept     = i_req_valid && req_ready_q;
        rq_wen_d   = rq_wen_q;
        rq_f3_d    = rq_f3_q;
        rq_addr_d  = rq_addr_q;
        rq_wdata_d = rq_wdata_q;
        if (accept) begin
            rq_wen_d   = i_req_wen;
            rq_f3_d    = i_req_funct3;
            rq_addr_d  = i_req_addr;
            rq_wdata_d = i_req_wdata;
        end
        lg  = rq_f3_d[1:0];
        off = rq_addr_d[OW-1:0];
        case (rq_f3_d)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            3'b011, 3'b110:                         legal = (XLEN == 64);
            default:                                legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        cross = (32'(off) + (32'd1 << lg)) > 32'(NB);
        trap  = !legal;
        split = legal && cross;
`else
        misal = (32'(off) & ((32'd1 << lg) - 32'd1)) != 32'd0;
        trap  = !legal || misal;
        split = 1'b0;
`endif
        buf_d = buf_q;
        if (state_q == S_WAIT0 && i_dmem_valid) buf_d[XLEN-1:0] = i_dmem_rdata;
        if (state_q == S_WAIT1 && i_dmem_valid) buf_d[DW-1:XLEN] = i_dmem_rdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)       state_d = trap ? S_RESP : S_BEAT0;
            S_BEAT0: if (i_dmem_ready) state_d = rq_wen_q ? (split ? S_BEAT1 : S_RESP) : S_WAIT0;
            S_WAIT0: if (i_dmem_valid) state_d = split ? S_BEAT1 : S_RESP;
            S_BEAT1: if (i_dmem_ready) state_d = rq_wen_q ? S_RESP : S_WAIT1;
            S_WAIT1: if (i_dmem_valid) state_d = S_RESP;
            S_RESP:                    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    logic [MW-1:0]   ones, mask_w;
    logic [DW-1:0]   wdat_w;
    logic [XLEN-1:0] base, raw, shl, ld;
    int unsigned     bits, sh;

    // Outputs for the coming cycle, derived from the next state so they leave flops
    always_comb begin
        case (lg)
            2'd0:    ones = MW'(8'h01);
            2'd1:    ones = MW'(8'h03);
            2'd2:    ones = MW'(8'h0F);
            default: ones = MW'(8'hFF);
        endcase
        mask_w = ones << off;
        wdat_w = DW'(rq_wdata_d) << {off, 3'b000};
        base   = {rq_addr_d[XLEN-1:OW], OW'(0)};
        raw    = XLEN'(buf_d >> {off, 3'b000});
        bits   = 32'd8 << lg;
        sh     = (bits >= XLEN) ? 32'd0 : 32'(XLEN) - bits;
        shl    = raw << sh;
        ld     = rq_f3_d[2] ? (shl >> sh) : XLEN'($signed(shl) >>> sh);

        req_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        rsp_valid_d  = 1'b0;
        rsp_trap_d   = 1'b0;
        rsp_rdata_d  = '0;
        dmem_addr_d  = '0;
        dmem_ren_d   = 1'b0;
        dmem_wen_d   = 1'b0;
        dmem_wdata_d = '0;
        dmem_mask_d  = '0;
        case (state_d)
            S_BEAT0: begin
                dmem_addr_d  = base;
                dmem_ren_d   = !rq_wen_d;
                dmem_wen_d   = rq_wen_d;
                dmem_mask_d  = mask_w[NB-1:0];
                dmem_wdata_d = wdat_w[XLEN-1:0];
            end
            S_BEAT1: begin
                dmem_addr_d  = base + XLEN'(NB);
                dmem_ren_d   = !rq_wen_d;
                dmem_wen_d   = rq_wen_d;
                dmem_mask_d  = mask_w[MW-1:NB];
                dmem_wdata_d = wdat_w[DW-1:XLEN];
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_trap_d  = trap;
                rsp_rdata_d = (!rq_wen_d && !trap) ? ld : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rq_wen_q     <= 1'b0;
            rq_f3_q      <= '0;
            rq_addr_q    <= '0;
            rq_wdata_q   <= '0;
            buf_q        <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_trap_q   <= 1'b0;
            rsp_rdata_q  <= '0;
            dmem_addr_q  <= '0;
            dmem_ren_q   <= 1'b0;
            dmem_wen_q   <= 1'b0;
            dmem_wdata_q <= '0;
            dmem_mask_q  <= '0;
        end else begin
            rq_wen_q     <= rq_wen_d;
            rq_f3_q      <= rq_f3_d;
            rq_addr_q    <= rq_addr_d;
            rq_wdata_q   <= rq_wdata_d;
            buf_q        <= buf_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_trap_q   <= rsp_trap_d;
            rsp_rdata_q  <= rsp_rdata_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_ren_q   <= dmem_ren_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_mask_q  <= dmem_mask_d;
        end
    end

    assign o_req_ready  = req_ready_q;
    assign o_busy       = busy_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_trap   = rsp_trap_q;
    assign o_rsp_rdata  = rsp_rdata_q;
    assign o_dmem_addr  = dmem_addr_q;
    assign o_dmem_ren   = dmem_ren_q;
    assign o_dmem_wen   = dmem_wen_q;
    assign o_dmem_wdata = dmem_wdata_q;
    assign o_dmem_mask  = dmem_mask_q;

endmodule
